// File: rtl/xm_debug_input_if.sv
// Front-panel pin bundle for the debugger input conditioner.
//   btn_i    : raw push-buttons, [0] action, [1] fwd, [2] bwd (async, active-high)
//   sw_i     : raw slide switches (async)
//   action_o : one-cycle pulse per accepted action press
//   cycFwd_o : one-cycle pulse per accepted fwd press
//   cycBwd_o : one-cycle pulse per accepted bwd press
//   data_o   : synchronised switch word
// The board side uses the master modport; the conditioner uses the slave modport.
interface xm_debug_input_if;
    logic [2:0]  btn_i;
    logic [15:0] sw_i;
    logic        action_o;
    logic        cycFwd_o;
    logic        cycBwd_o;
    logic [15:0] data_o;

    modport master (
        output btn_i,
        output sw_i,
        input  action_o,
        input  cycFwd_o,
        input  cycBwd_o,
        input  data_o
    );

    modport slave (
        input  btn_i,
        input  sw_i,
        output action_o,
        output cycFwd_o,
        output cycBwd_o,
        output data_o
    );
endinterface

// File: rtl/xm_debug_input.sv
// Front-panel input conditioner for the debugger.
// Synchronises the raw buttons and switches, debounces each button with a
// four-state FSM, and turns every accepted press into exactly one registered,
// one-cycle pulse. Simultaneous presses are serialised with priority
// action > fwd > bwd; no press is ever dropped.
// Ports:
//   clk_i   : system clock, rising edge
//   arst_ni : asynchronous active-low reset
//   bus     : slave side of xm_debug_input_if (btn_i, sw_i in; pulses, data_o out)
module xm_debug_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input logic             clk_i,
    input logic             arst_ni,
    xm_debug_input_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchronisers
    logic [2:0]  btn_meta;
    logic [2:0]  btn_sync;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= bus.btn_i;
            btn_sync <= btn_meta;
            sw_meta  <= bus.sw_i;
            sw_sync  <= sw_meta;
        end
    end

    assign bus.data_o = sw_sync;

    // Per-button debounce FSMs
    state_t           state_q [3];
    state_t           state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       req_q;
    logic [2:0]       req_d;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= RELEASE_WAIT;
                cnt_q[i]   <= '0;
            end
            req_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            req_q <= req_d;
        end
    end

    // The count is compared after incrementing, so the sample that moved the
    // FSM out of IDLE/HELD counts as the first of the DEBOUNCE_CYCLES stable
    // samples.
    always_comb begin
        req_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (btn_sync[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync[i]) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        if (cnt_d[i] == CNT_LAST) begin
                            state_d[i] = HELD;
                            req_d[i]   = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!btn_sync[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync[i]) begin
                        state_d[i] = HELD;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        if (cnt_d[i] == CNT_LAST) begin
                            state_d[i] = IDLE;
                        end
                    end
                end
                default: begin
                    state_d[i] = RELEASE_WAIT;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Pending flags and fixed-priority pulse arbiter
    logic [2:0] pend_q;
    logic [2:0] grant;
    logic [2:0] pulse_q;

    always_comb begin
        grant = '0;
        if (pend_q[0]) begin
            grant = 3'b001;
        end else if (pend_q[1]) begin
            grant = 3'b010;
        end else if (pend_q[2]) begin
            grant = 3'b100;
        end
    end

    // A req arriving for a button that is already pending (even the one being
    // granted this cycle) is absorbed rather than queued a second time.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pend_q  <= '0;
            pulse_q <= '0;
        end else begin
            pend_q  <= (pend_q | req_q) & ~grant;
            pulse_q <= grant;
        end
    end

    assign bus.action_o = pulse_q[0];
    assign bus.cycFwd_o = pulse_q[1];
    assign bus.cycBwd_o = pulse_q[2];

endmodule

// File: tb/tb_xm_debug_input.sv
// Self-checking bench for xm_debug_input with DEBOUNCE_CYCLES = 4.
// Expected pulses (due cycle + which output) are queued when a press is
// driven; a monitor compares each observed pulse against the queue head.
module tb_xm_debug_input;

    localparam int unsigned DEB = 4;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    xm_debug_input_if bus ();

    xm_debug_input #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .clk_i  (clk),
        .arst_ni(arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    typedef struct {
        int unsigned due;
        logic [2:0]  which;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]  mask;
        bit          bounce;
        bit          rel_bounce;
        int unsigned hold;
    } press_vec_t;

    typedef struct {
        logic [15:0] sw;
        logic [15:0] prev;
    } sw_vec_t;

    press_vec_t press_tbl[6];
    sw_vec_t    sw_tbl[5];

    logic [2:0] mon_pulses;
    exp_t       mon_e;
    int unsigned n_mark;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_press(input logic [2:0] mask, input int unsigned n, input int unsigned extra);
        int unsigned k;
        k = 0;
        for (int unsigned b = 0; b < 3; b++) begin
            if (mask[b]) begin
                sb.push_back('{n + 3 + DEB + k + extra, 3'(1 << b)});
                k++;
            end
        end
    endtask

    // Called at a negedge with all FSMs idle.
    task automatic run_press(input logic [2:0] mask, input bit bounce, input bit rel_bounce,
                             input int unsigned hold);
        int unsigned n;
        bus.btn_i = mask;
        n = cyc + 1;
        push_press(mask, n, bounce ? 3 : 0);
        if (bounce) begin
            @(negedge clk);
            @(negedge clk);
            bus.btn_i = '0;
            @(negedge clk);
            bus.btn_i = mask;
        end
        repeat (hold) @(negedge clk);
        bus.btn_i = '0;
        if (rel_bounce) begin
            @(negedge clk);
            bus.btn_i = mask;
            @(negedge clk);
            bus.btn_i = '0;
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        press_tbl[0] = '{3'b001, 1'b0, 1'b0, 50};
        press_tbl[1] = '{3'b010, 1'b1, 1'b1, 20};
        press_tbl[2] = '{3'b111, 1'b0, 1'b0, 20};
        press_tbl[3] = '{3'b100, 1'b0, 1'b0, 10};
        press_tbl[4] = '{3'b011, 1'b0, 1'b1, 15};
        press_tbl[5] = '{3'b110, 1'b1, 1'b0, 18};

        sw_tbl[0] = '{16'hA5C3, 16'h0000};
        sw_tbl[1] = '{16'hFFFF, 16'hA5C3};
        sw_tbl[2] = '{16'h0001, 16'hFFFF};
        sw_tbl[3] = '{16'h8000, 16'h0001};
        sw_tbl[4] = '{16'hA5C3, 16'h8000};

        bus.btn_i = '0;
        bus.sw_i  = '0;
        arst_n    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_pulses = {bus.cycBwd_o, bus.cycFwd_o, bus.action_o};
                if (mon_pulses != 3'b000) begin
                    check("pulse_onehot", 32'($countones(mon_pulses)), 32'd1);
                    if (sb.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", mon_pulses, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("pulse_kind", 32'(mon_pulses), 32'(mon_e.which));
                        check("pulse_cycle", cyc, mon_e.due);
                    end
                end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                    mon_e = sb.pop_front();
                    compared++;
                    mismatched++;
                    $display("FAIL missing_pulse: got none at cycle %0d, expected %b", cyc, mon_e.which);
                end
            end
            begin
                #100000;
                compared++;
                mismatched++;
                $display("FAIL watchdog: got timeout, expected completion");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_action", 32'(bus.action_o), 32'd0);
        check("rst_fwd", 32'(bus.cycFwd_o), 32'd0);
        check("rst_bwd", 32'(bus.cycBwd_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'd0);
        arst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Table-driven presses
        for (int i = 0; i < 6; i++) begin
            run_press(press_tbl[i].mask, press_tbl[i].bounce, press_tbl[i].rel_bounce,
                      press_tbl[i].hold);
        end

        // Switch synchroniser latency
        for (int i = 0; i < 5; i++) begin
            bus.sw_i = sw_tbl[i].sw;
            @(negedge clk);
            check("data_before", 32'(bus.data_o), 32'(sw_tbl[i].prev));
            @(negedge clk);
            check("data_after", 32'(bus.data_o), 32'(sw_tbl[i].sw));
        end

        // Button held through reset release: no pulse, then one clean press
        arst_n    = 1'b0;
        bus.btn_i = 3'b001;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (20) @(negedge clk);
        bus.btn_i = '0;
        repeat (8) @(negedge clk);
        run_press(3'b001, 1'b0, 1'b0, 10);

        // Async reset mid-hold clears data_o without a clock edge
        bus.btn_i = 3'b001;
        push_press(3'b001, cyc + 1, 0);
        repeat (12) @(negedge clk);
        check("data_pre_reset", 32'(bus.data_o), 32'hA5C3);
        #2;
        arst_n = 1'b0;
        #1;
        check("data_async_clear", 32'(bus.data_o), 32'd0);
        check("pulses_async_clear", 32'({bus.cycBwd_o, bus.cycFwd_o, bus.action_o}), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_i = '0;
        repeat (10) @(negedge clk);

        // Reset two cycles before the expected bwd pulse discards it
        bus.btn_i = 3'b100;
        n_mark    = cyc + 1;
        repeat (6) @(negedge clk);
        check("discard_setup_cycle", cyc, n_mark + 5);
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (15) @(negedge clk);
        bus.btn_i = '0;
        repeat (12) @(negedge clk);

        // Recovery after the discarded press
        run_press(3'b100, 1'b0, 1'b0, 10);
        repeat (5) @(negedge clk);

        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL leftover_pulse: got none, expected %b at cycle %0d", mon_e.which, mon_e.due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/xm_debug_input.md
# xm_debug_input

Front-panel input conditioner for the debugger. Takes the three raw push-buttons and the 16 raw slide switches from the board and produces the clean, synchronous controls the debugger consumes: a single one-cycle pulse per physical press for action, cycle-forward and cycle-backward, plus a synchronised 16-bit data word. It sits directly between the board pins and the debugger's `action_i`/`cycFwd_i`/`cycBwd_i`/`data_i` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz); minimum 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk_i`  in  1  system clock; single clock domain, all flops on the rising edge.
- `arst_ni`  in  1  reset, asynchronous, active-low.
- `btn_i`  in  3  raw buttons, active-high, asynchronous; [0] action, [1] fwd, [2] bwd.
- `sw_i`  in  16  raw switches, asynchronous.
- `action_o`  out  1  one-cycle press pulse for action.
- `cycFwd_o`  out  1  one-cycle press pulse for fwd.
- `cycBwd_o`  out  1  one-cycle press pulse for bwd.
- `data_o`  out  16  synchronised switch word.

## Operation
- Synchronisers: every bit of `btn_i` and `sw_i` goes through a 2-flop synchroniser. `data_o` is the second-stage switch value. There is no debounce on the switches.
- Per-button FSM with four states, driven by the synchronised level `s`, and a per-button counter `cnt`:
  - IDLE (released): when `s`=1, clear `cnt` and go to PRESS_WAIT.
  - PRESS_WAIT: if `s`=0, return to IDLE. Otherwise increment `cnt`. When `s`=1 and `cnt`=DEBOUNCE_CYCLES-1, go to HELD and raise the button's `req` flag.
  - HELD: when `s`=0, clear `cnt` and go to RELEASE_WAIT.
  - RELEASE_WAIT: if `s`=1, return to HELD with no new req. Otherwise increment `cnt`. When `s`=0 and `cnt`=DEBOUNCE_CYCLES-1, go to IDLE.
- Reset state of every FSM is RELEASE_WAIT with `cnt`=0. A button held across reset release therefore produces no pulse. It must be released and stable low for DEBOUNCE_CYCLES before a press is accepted.
- Arbiter: pending flags `pend[2:0]` are set by `req` and cleared when the pulse is issued.
  - At most one output pulse per cycle.
  - Priority is action > fwd > bwd.
  - A lower-priority pending press is issued on a following cycle once it is highest pending. It is never dropped.
  - A new `req` on a button whose `pend` is already set is absorbed. This cannot happen within DEBOUNCE_CYCLES ≥ 2.
- Outputs `action_o`, `cycFwd_o`, `cycBwd_o` are registered, mutually exclusive, and high for exactly one cycle per accepted press. Holding a button never repeats.

## Timing
- Reset (`arst_ni`=0, async): all synchroniser flops, `cnt`, `pend`, pulse outputs and `data_o` go to 0 immediately. FSMs go to RELEASE_WAIT.
- Switch latency: a `sw_i` change sampled at edge N appears on `data_o` after edge N+1. That is 2 flops.
- Press latency, uncontended: `btn_i` high first sampled at edge N.
  - `s`=1 after edge N+1.
  - The FSM enters PRESS_WAIT at edge N+2.
  - HELD plus `req` at edge N+1+DEBOUNCE_CYCLES.
  - `pend` set at edge N+2+DEBOUNCE_CYCLES.
  - The pulse is high for the one cycle following edge N+3+DEBOUNCE_CYCLES.
- Contention: each extra higher-priority pending press adds one cycle.
- A bounce (one `s` sample of the opposite level) in PRESS_WAIT or RELEASE_WAIT restarts qualification from the start. A 1-sample glitch in IDLE or HELD only enters the wait state and returns.
- Reset asserted mid-qualification or with a pulse pending: the pending pulse is discarded and no pulse is emitted.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset with all inputs 0, then 6 cycles low, then hold `btn_i[0]` high from edge N → exactly one `action_o` pulse, in the cycle after edge N+7. `cycFwd_o`=`cycBwd_o`=0 throughout. No further pulse while the button is held for 50 cycles.
- Bounce: `btn_i[1]` goes 1,1,0,1,1,1,1,… → `cycFwd_o` pulse delayed 3 cycles versus a clean press. A bounce on release (0,1,0,0,0,0) produces no second pulse.
- Simultaneous: all three buttons rise on the same edge after idle → `action_o`, `cycFwd_o`, `cycBwd_o` pulse on three consecutive cycles, in that order, each exactly once.
- Button held high through reset release → no pulse. After release for ≥6 cycles and a re-press, exactly one pulse.
- `sw_i` changes 0x0000→0xA5C3 at edge N → `data_o`=0xA5C3 after edge N+1, and 0x0000 before. Async reset mid-hold clears `data_o` to 0 immediately.
- Press `btn_i[2]`, then assert reset 2 cycles before the expected pulse → no `cycBwd_o` pulse at all.
